// File: rtl/eyeriss_pkg.sv
// Shared types and default widths for the Eyeriss scratchpad / GLB banks.
package eyeriss_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } spad_state_t;

    localparam int unsigned SPAD_ADDR_BITS = 3;
    localparam int unsigned SPAD_DATA_BITS = 2;
    localparam int unsigned GLB_ADDR_BITS  = 8;
    localparam int unsigned GLB_DATA_BITS  = 6;

endpackage

// File: rtl/spad_mem_array.sv
// Storage array: one synchronous write port, two combinational read taps
// (tap a feeds the accumulate adder, tap b feeds the read path).
module spad_mem_array
    import eyeriss_pkg::*;
#(
    parameter int unsigned ADDR_BITS = SPAD_ADDR_BITS,
    parameter int unsigned DATA_BITS = SPAD_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr_a,
    output logic [DATA_BITS-1:0] rdata_a,
    input  logic [ADDR_BITS-1:0] raddr_b,
    output logic [DATA_BITS-1:0] rdata_b
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    // Single write port; contents are not reset (the bank clears them by sweep).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read taps.
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
    end

endmodule

// File: rtl/spad_rw_bank.sv
// Scratchpad bank: one write port (overwrite / accumulate), one read port
// with a single registered output stage, and a zeroing sweep after reset.
module spad_rw_bank
    import eyeriss_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = SPAD_ADDR_BITS,
    parameter int unsigned DATA_BITS      = SPAD_DATA_BITS,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic                 wr_acc,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_valid,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 rd_ready,
    output logic                 busy
);

    spad_state_t          state;
    spad_state_t          state_next;
    logic [ADDR_BITS-1:0] clr_cnt;

    logic                 wr_fire;
    logic                 rd_fire;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] acc_word;
    logic [DATA_BITS-1:0] tap_word;
    logic [DATA_BITS-1:0] rd_word;

    spad_mem_array #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (wr_addr),
        .rdata_a (acc_word),
        .raddr_b (rd_addr),
        .rdata_b (tap_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? CLEAR : RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave CLEAR after the last address has been zeroed.
    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_cnt == '1) begin
            state_next = RUN;
        end
    end

    // Handshake outputs; held off while reset is asserted.
    always_comb begin
        busy         = reset ? CLEAR_ON_RESET : (state == CLEAR);
        wr_ready     = ~reset & (state == RUN);
        rd_req_ready = ~reset & (state == RUN) & (~rd_valid | rd_ready);
    end

    // Clear sweep address counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_BITS'(1);
        end
    end

    // Single memory write port shared by the clear sweep and the write port.
    always_comb begin
        wr_fire   = wr_valid & wr_ready;
        rd_fire   = rd_req_valid & rd_req_ready;
        mem_we    = wr_fire;
        mem_waddr = wr_addr;
        mem_wdata = wr_acc ? acc_word + wr_data : wr_data;
        if (!reset && state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
        end
    end

    // Write-first bypass: a same-cycle write to the read address wins.
    always_comb begin
        rd_word = (wr_fire && wr_addr == rd_addr) ? mem_wdata : tap_word;
    end

    // Read output register: load on fire, drop valid on pop, hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (rd_fire) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_word;
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spad_rw_bank.sv
// Randomized and directed bench for spad_rw_bank against a behavioural model.
module tb_spad_rw_bank;

    localparam int AB    = 3;
    localparam int DB    = 2;
    localparam int DEPTH = 8;
    localparam int MOD   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_acc;
    logic [AB-1:0] wr_addr;
    logic [DB-1:0] wr_data;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AB-1:0] rd_addr;
    logic          rd_valid;
    logic [DB-1:0] rd_data;
    logic          rd_ready;
    logic          busy;

    always #5 clk = ~clk;

    spad_rw_bank #(
        .ADDR_BITS      (AB),
        .DATA_BITS      (DB),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_acc       (wr_acc),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: word contents, cycles left in the clear sweep, output register.
    int m_mem [DEPTH];
    int clr_left = DEPTH;
    bit o_valid  = 1'b0;
    int o_data   = 0;

    // Values sampled in the most recent cycle, used by directed checks.
    int s_rd_data;
    bit s_rd_valid;
    bit s_rq_ready;
    int busy_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic cycle(input bit rst, input bit wv, input bit wa, input int waddr, input int wdata,
                         input bit rv, input int raddr, input bit rdy);
        bit exp_wr_rdy, exp_rq_rdy, exp_busy;
        reset        = rst;
        wr_valid     = wv;
        wr_acc       = wa;
        wr_addr      = AB'(waddr);
        wr_data      = DB'(wdata);
        rd_req_valid = rv;
        rd_addr      = AB'(raddr);
        rd_ready     = rdy;
        @(negedge clk);
        exp_wr_rdy = !rst && clr_left == 0;
        exp_rq_rdy = exp_wr_rdy && (!o_valid || rdy);
        exp_busy   = rst || clr_left != 0;
        check("busy", busy, exp_busy);
        check("wr_ready", wr_ready, exp_wr_rdy);
        check("rd_req_ready", rd_req_ready, exp_rq_rdy);
        check("rd_valid", rd_valid, o_valid);
        check("rd_data", rd_data, o_data);
        s_rd_data  = int'(rd_data);
        s_rd_valid = rd_valid;
        s_rq_ready = rd_req_ready;
        if (busy && !rst) busy_cycles++;
        @(posedge clk);
        if (rst) begin
            clr_left = DEPTH;
            o_valid  = 1'b0;
            o_data   = 0;
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) foreach (m_mem[i]) m_mem[i] = 0;
        end else begin
            if (wv) m_mem[waddr] = wa ? (m_mem[waddr] + wdata) % MOD : wdata;
            if (rv && exp_rq_rdy) begin
                o_valid = 1'b1;
                o_data  = m_mem[raddr];
            end else if (rdy) begin
                o_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        foreach (m_mem[i]) m_mem[i] = 0;

        // Reset and clear sweep length
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 1, 0, 3, 1, 1, 3, 1);
        busy_cycles = 0;
        idle(12);
        check("clear_len", busy_cycles, 8);

        // All words read back as zero
        for (int a = 0; a < DEPTH; a++) cycle(0, 0, 0, 0, 0, 1, a, 1);
        idle(1);

        // Reset mid-clear restarts the sweep; prior contents are wiped
        cycle(0, 1, 0, 7, 3, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 7, 1);
        idle(1);
        check("pre_reset_w7", s_rd_data, 3);
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        idle(5);
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        busy_cycles = 0;
        idle(10);
        check("clear_len_restart", busy_cycles, 8);
        cycle(0, 0, 0, 0, 0, 1, 7, 1);
        idle(1);
        check("w7_cleared", s_rd_data, 0);

        // Overwrite then read with one-cycle latency
        cycle(0, 1, 0, 2, 3, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 2, 1);
        idle(1);
        check("ow_lat_valid", s_rd_valid, 1);
        check("ow_lat_data", s_rd_data, 3);

        // Accumulate wraps modulo 4
        cycle(0, 1, 0, 4, 1, 0, 0, 1);
        cycle(0, 1, 1, 4, 2, 0, 0, 1);
        cycle(0, 1, 1, 4, 2, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 4, 1);
        idle(1);
        check("acc_wrap", s_rd_data, 1);

        // Same-cycle write/read bypass, overwrite and accumulate
        cycle(0, 1, 0, 5, 2, 1, 5, 1);
        idle(1);
        check("bypass_ow", s_rd_data, 2);
        cycle(0, 1, 1, 5, 3, 1, 5, 1);
        idle(1);
        check("bypass_acc", s_rd_data, 1);

        // Backpressure holds the output and blocks the next read
        cycle(0, 1, 0, 1, 1, 0, 0, 1);
        cycle(0, 1, 0, 2, 2, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, 1, 2, 0);
            check("bp_hold_data", s_rd_data, 1);
            check("bp_hold_valid", s_rd_valid, 1);
            check("bp_req_blocked", s_rq_ready, 0);
        end
        cycle(0, 0, 0, 0, 0, 1, 2, 1);
        check("bp_release_ready", s_rq_ready, 1);
        idle(1);
        check("bp_release_data", s_rd_data, 2);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 149) == 0,
                  1'($urandom), 1'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(0, MOD - 1),
                  1'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
